// File: rtl/twos_compl_if.sv
// ============================================================================
// Module   : twos_compl_if
// Brief    : Operand/result bundle for the twos_compl adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface twos_compl_if;
  logic [15:0] x;
  logic [15:0] y;
  logic        subc;
  logic [15:0] s;
  logic [15:0] c;

  modport master (
    output x,
    output y,
    output subc,
    input  s,
    input  c
  );

  modport slave (
    input  x,
    input  y,
    input  subc,
    output s,
    output c
  );
endinterface

`default_nettype wire

// File: rtl/twos_compl.sv
// ============================================================================
// Module   : twos_compl
// Brief    : 16-bit ripple-carry add/subtract with registered sum and carries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_compl (
  input  wire         clk,
  input  wire         rst_n,
  twos_compl_if.slave bus
);

  localparam int unsigned C_WIDTH = 16;

  logic [C_WIDTH-1:0] w_yb;
  logic [C_WIDTH-1:0] w_cin;
  logic [C_WIDTH-1:0] w_sum;
  logic [C_WIDTH-1:0] w_cout;
  logic [C_WIDTH-1:0] r_s;
  logic [C_WIDTH-1:0] r_c;

  // subc both inverts B and supplies the +1 through the bit-0 carry-in
  assign w_yb  = bus.y ^ {C_WIDTH{bus.subc}};
  assign w_cin = {w_cout[C_WIDTH-2:0], bus.subc};

  genvar gi;
  generate
    for (gi = 0; gi < C_WIDTH; gi = gi + 1) begin : g_stage
      assign w_sum[gi]  = bus.x[gi] ^ w_yb[gi] ^ w_cin[gi];
      assign w_cout[gi] = (bus.x[gi] & w_yb[gi]) |
                          (bus.x[gi] & w_cin[gi]) |
                          (w_yb[gi] & w_cin[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= '0;
    end else begin
      r_s <= w_sum;
      r_c <= w_cout;
    end
  end

  assign bus.s = r_s;
  assign bus.c = r_c;

endmodule

`default_nettype wire

// File: tb/tb_twos_compl.sv
// ============================================================================
// Module   : tb_twos_compl
// Brief    : Directed-vector bench for twos_compl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twos_compl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  twos_compl_if bus ();

  twos_compl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic subc);
    bus.x    = x;
    bus.y    = y;
    bus.subc = subc;
  endtask

  // Drive one vector, clock it in, and check the registered result.
  task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y,
                    input logic subc, input logic [15:0] es, input logic [15:0] ec);
    drive(x, y, subc);
    @(posedge clk);
    #1;
    chk({tag, ".s"}, bus.s, es);
    chk({tag, ".c"}, bus.c, ec);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(16'hAAAA, 16'hFFFF, 1'b0);

    // reset held for two edges with live operands
    @(posedge clk);
    #1;
    chk("rst1.s", bus.s, 16'h0000);
    chk("rst1.c", bus.c, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst2.s", bus.s, 16'h0000);
    chk("rst2.c", bus.c, 16'h0000);

    rst_n = 1'b1;
    op("add_ones", 16'hAAAA, 16'hFFFF, 1'b0, 16'hAAA9, 16'hFFFE);
    op("add_zero", 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 16'h0000);
    op("sub_ones", 16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAB, 16'h0000);
    op("sub_5_3",  16'h0005, 16'h0003, 1'b1, 16'h0002, 16'hFFFD);
    op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF);
    op("sub_eq",   16'h1234, 16'h1234, 1'b1, 16'h0000, 16'hFFFF);
    op("sub_neg",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 16'h0000);
    op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF);

    // inputs changing between edges must not disturb the outputs
    drive(16'h1111, 16'h2222, 1'b1);
    #3;
    chk("hold.s", bus.s, 16'h8000);
    chk("hold.c", bus.c, 16'h7FFF);

    // back-to-back with a one-edge reset pulse in the middle
    op("b2b1", 16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAB, 16'h0000);
    op("b2b2", 16'h0005, 16'h0003, 1'b1, 16'h0002, 16'hFFFD);
    rst_n = 1'b0;
    op("b2b_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    op("b2b3", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF);
    op("b2b4", 16'hAAAA, 16'hFFFF, 1'b0, 16'hAAA9, 16'hFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twos_compl.md
# twos_compl

16-bit two's-complement adder/subtractor with a registered sum and a registered per-bit carry vector. When `subc` is 0 it computes `x + y`; when `subc` is 1 it computes `x - y` as `x + ~y + 1`. It is a leaf arithmetic block for datapaths that need the full internal carry chain, for example for flag generation or debug. It is built as a 16-stage ripple-carry chain of full-adder cells, followed by one output register stage.

## Interface
- No parameters; width fixed at 16 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `x`  input  16  operand A, two's complement or unsigned (identical bit-level behaviour).
- `y`  input  16  operand B.
- `subc`  input  1  operation select: 0 = add, 1 = subtract. Also serves as the carry-in to bit 0.
- `s`  output  16  registered sum/difference, bits [15:0].
- `c`  output  16  registered carry vector; `c[i]` is the carry-out of stage i; `c[15]` is the final carry-out.

## Operation
- Operand B per stage: `yb[i] = y[i] XOR subc`.
- Carry-in: `cin[0] = subc`; `cin[i] = cout[i-1]` for i ≥ 1.
- Each stage i:
  - `sum[i] = x[i] ^ yb[i] ^ cin[i]`
  - `cout[i] = x[i]&yb[i] | x[i]&cin[i] | yb[i]&cin[i]`
- Result is modulo 2^16. No saturation and no overflow output.
  - Signed overflow is derivable externally as `c[15] ^ c[14]`.
- Subtract convention: `c[15]=1` means no borrow (x ≥ y unsigned).
- Add convention: `c[15]=1` means unsigned carry-out.
- Register update on each rising `clk`:
  - `rst_n == 0`: `s <= 0`, `c <= 0`. Inputs are ignored.
  - Otherwise: `s <= sum`, `c <= cout`, computed from the x/y/subc values present at that edge.
- No internal state besides the 32 output flops; no FSM.
- All bits of `c` are exposed, not only the MSB carry.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on `s`/`c` immediately after edge N.
- Throughput: one operation per cycle. No handshake; a new operand pair is accepted every edge.
- Reset:
  - Synchronous. `s` and `c` read 0x0000 after the first rising edge with `rst_n` low.
  - Before that first edge, outputs are undefined.
- Reset mid-operation: the result of the current edge is discarded. Outputs hold 0 on every edge while `rst_n` is low.
- First valid result appears on the first edge with `rst_n` high.
- Combinational path: the full 16-stage ripple from `subc`/x/y to the `s`/`c` D-inputs must meet one `clk` period.
- Input changes between edges have no effect on outputs.

## Test plan
- Reset: hold `rst_n=0` for 2 edges with `x=0xAAAA`, `y=0xFFFF`, `subc=0` → `s=0x0000`, `c=0x0000`.
- Add, all-ones: `x=0xAAAA`, `y=0xFFFF`, `subc=0` → next edge `s=0xAAA9`, `c=0xFFFE`.
- Add zero: `x=0xAAAA`, `y=0x0000`, `subc=0` → `s=0xAAAA`, `c=0x0000`.
- Subtract all-ones: `x=0xAAAA`, `y=0xFFFF`, `subc=1` → `s=0xAAAB`, `c=0x0000` (borrow).
- Subtract small values and wrap:
  - `x=0x0005`, `y=0x0003`, `subc=1` → `s=0x0002`, `c=0xFFFD`.
  - `x=0xFFFF`, `y=0x0001`, `subc=0` → `s=0x0000`, `c=0xFFFF`.
- Back-to-back with reset pulse:
  - Apply the three vectors above on consecutive edges → each result appears exactly one edge later.
  - Assert `rst_n=0` for one edge mid-sequence → outputs are 0 on that edge, then resume with the next vector.
